vga_sync_rx: RTL

//  Receive-side counterpart of the VGA sync generator: watches hsync/vsync and rebuilds pixel_x,

---
 rtl/vga_sync_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: rebuilds pixel position from hsync/vsync, measures line/frame
// length, locks after consecutive good frames and pulses sync_err on faults.
module vga_sync_rx #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic       sync_err
);
    localparam int          H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int          V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] LOSS    = 11'(2 * H_TOTAL);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state_q;
    logic        hs_q, vs_q, meas_valid_q, locked_q, sync_err_q;
    logic [9:0]  hcnt_q, vcnt_q, h_total_q, v_total_q, fcnt_q;
    logic [10:0] lcnt_q, lcnt_d;
    logic [3:0]  good_q, good_d;
    logic        hfall, vfall, hwrap, line_bad, frame_bad, loss, fault;

    assign hfall     = p_tick & hs_q & ~hsync;
    assign vfall     = p_tick & vs_q & ~vsync;
    assign hwrap     = ~hfall & (hcnt_q == 10'(H_TOTAL - 1));
    assign lcnt_d    = lcnt_q + 11'd1;
    assign good_d    = good_q + 4'd1;
    assign line_bad  = hfall & meas_valid_q & (lcnt_d != 11'(H_TOTAL));
    assign frame_bad = vfall & (fcnt_q != 10'(V_TOTAL));
    // lcnt parks at LOSS, so a dead hsync is reported only once
    assign loss      = p_tick & ~hfall & (lcnt_d == LOSS);
    assign fault     = line_bad | frame_bad | loss;

    assign pixel_x  = hcnt_q;
    assign pixel_y  = vcnt_q;
    assign locked   = locked_q;
    assign h_total  = h_total_q;
    assign v_total  = v_total_q;
    assign sync_err = sync_err_q;
    assign video_on = locked_q & (hcnt_q < 10'(H_DISPLAY)) & (vcnt_q < 10'(V_DISPLAY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SEARCH;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            fcnt_q       <= '0;
            lcnt_q       <= '0;
            good_q       <= '0;
        end else begin
            sync_err_q <= 1'b0;
            if (p_tick) begin
                hs_q   <= hsync;
                vs_q   <= vsync;
                hcnt_q <= hfall ? 10'(H_DISPLAY + H_FRONT) : hwrap ? 10'd0 : hcnt_q + 10'd1;
                if (vfall)
                    vcnt_q <= 10'(V_DISPLAY + V_FRONT);
                else if (hwrap)
                    vcnt_q <= (vcnt_q == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt_q + 10'd1;
                if (hfall) begin
                    if (meas_valid_q)
                        h_total_q <= (lcnt_d > 11'd1023) ? 10'd1023 : lcnt_d[9:0];
                    lcnt_q       <= '0;
                    meas_valid_q <= 1'b1;
                end else if (lcnt_q != LOSS) begin
                    lcnt_q <= lcnt_d;
                end
                if (loss)
                    meas_valid_q <= 1'b0;
                // an hsync fall coincident with vsync fall opens the new frame's count
                if (vfall) begin
                    v_total_q <= fcnt_q;
                    fcnt_q    <= {9'd0, hfall};
                end else if (hfall && fcnt_q != 10'h3ff) begin
                    fcnt_q <= fcnt_q + 10'd1;
                end
                case (state_q)
                    SEARCH: if (vfall) begin
                        state_q <= TRACK;
                        good_q  <= '0;
                    end
                    TRACK: if (fault) begin
                        state_q    <= SEARCH;
                        sync_err_q <= 1'b1;
                    end else if (vfall) begin
                        good_q <= good_d;
                        if (good_d == 4'(LOCK_FRAMES)) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                    LOCKED: if (fault) begin
                        state_q    <= SEARCH;
                        locked_q   <= 1'b0;
                        sync_err_q <= 1'b1;
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end
endmodule
